// File: rtl/mchan_ext_pkg.sv
// Shared definitions for the external-side AXI read/write adapters:
// the AR/AW issue FSM states, fixed AXI encodings and the beat count helper.
package mchan_ext_pkg;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_VALID = 1'b1
    } ar_state_e;

    localparam logic [2:0] AXI_SIZE_64B    = 3'd3;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // Beats-minus-one for a byte range on a 64-bit bus; only length bits
    // [10:0] can reach the 8-bit AXI len, higher bits are truncated away.
    function automatic logic [7:0] calc_beats_m1(input logic [2:0]  add_lo,
                                                 input logic [10:0] len_lo);
        logic [3:0] lo_sum;
        lo_sum = {1'b0, add_lo} + {1'b0, len_lo[2:0]};
        return len_lo[10:3] + {7'd0, lo_sum[3]};
    endfunction

endpackage

// File: rtl/ext_rx_if_if.sv
// AXI read-channel bundle (AR + R) between the external RX adapter and the bus.
interface ext_rx_if_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_USER_WIDTH = 6,
    parameter int unsigned AXI_ID_WIDTH   = 4
) ();

    logic                      ar_valid;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_region;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [3:0]                ar_qos;
    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_ready;

    logic                      r_valid;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_ready;

    modport master (
        output ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size,
               ar_burst, ar_lock, ar_cache, ar_qos, ar_id, ar_user,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last, r_id, r_user,
        output r_ready
    );

    modport slave (
        input  ar_valid, ar_addr, ar_prot, ar_region, ar_len, ar_size,
               ar_burst, ar_lock, ar_cache, ar_qos, ar_id, ar_user,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last, r_id, r_user,
        input  r_ready
    );

endinterface

// File: rtl/ext_rx_if.sv
// External RX adapter: turns read commands into AXI AR bursts and forwards
// R beats to the channel, tracking outstanding bursts and response errors.
module ext_rx_if
    import mchan_ext_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_USER_WIDTH  = 6,
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned EXT_ADD_WIDTH   = 29,
    parameter int unsigned EXT_TID_WIDTH   = 4,
    parameter int unsigned MCHAN_LEN_WIDTH = 15,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [EXT_ADD_WIDTH-1:0]   cmd_add_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    input  logic [EXT_TID_WIDTH-1:0]   cmd_tid_i,
    input  logic                       cmd_bst_i,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,

    input  logic                       valid_tid_i,
    output logic                       release_tid_o,
    output logic [EXT_TID_WIDTH-1:0]   res_tid_o,
    output logic                       synch_req_o,

    output logic [AXI_DATA_WIDTH-1:0]  rx_data_dat_o,
    output logic                       rx_data_last_o,
    output logic [EXT_TID_WIDTH-1:0]   rx_data_tid_o,
    output logic                       rx_data_req_o,
    input  logic                       rx_data_gnt_i,

    input  logic                       err_clr_i,
    output logic                       err_o,

    ext_rx_if_if.master                axi_master
);

    localparam int unsigned OUTST_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUTST_W-1:0] OUTST_MAX = OUTST_W'(MAX_OUTSTANDING);
    localparam logic [OUTST_W-1:0] OUTST_ONE = OUTST_W'(1);

    ar_state_e                 state;
    logic                      ar_valid_q;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]                ar_len_q;
    logic [AXI_ID_WIDTH-1:0]   ar_id_q;
    logic [1:0]                ar_burst_q;
    logic [OUTST_W-1:0]        outstanding;
    logic                      err_q;

    logic accept;
    logic r_hs;
    logic r_last_hs;
    logic unused_inputs;

    assign accept = cmd_req_i && valid_tid_i && (outstanding < OUTST_MAX) &&
                    ((state == AR_IDLE) || axi_master.ar_ready);
    assign r_hs      = axi_master.r_valid && rx_data_gnt_i;
    assign r_last_hs = r_hs && axi_master.r_last;

    // A new accept while AR_VALID reloads the registers on the ready edge,
    // giving one AR per cycle without passing through AR_IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= AR_IDLE;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_id_q    <= '0;
            ar_burst_q <= '0;
        end else if (accept) begin
            state      <= AR_VALID;
            ar_valid_q <= 1'b1;
            ar_addr_q  <= AXI_ADDR_WIDTH'(cmd_add_i);
            ar_len_q   <= calc_beats_m1(cmd_add_i[2:0], cmd_len_i[10:0]);
            ar_id_q    <= AXI_ID_WIDTH'(cmd_tid_i);
            ar_burst_q <= cmd_bst_i ? AXI_BURST_INCR : AXI_BURST_FIXED;
        end else if ((state == AR_VALID) && axi_master.ar_ready) begin
            state      <= AR_IDLE;
            ar_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding <= '0;
        end else if (accept && !r_last_hs) begin
            outstanding <= outstanding + OUTST_ONE;
        end else if (!accept && r_last_hs && (outstanding != '0)) begin
            outstanding <= outstanding - OUTST_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (r_hs && axi_master.r_resp[1]) begin
            err_q <= 1'b1;
        end else if (err_clr_i) begin
            err_q <= 1'b0;
        end
    end

    assign cmd_gnt_o = accept;
    assign err_o     = err_q;

    assign axi_master.ar_valid  = ar_valid_q;
    assign axi_master.ar_addr   = ar_addr_q;
    assign axi_master.ar_len    = ar_len_q;
    assign axi_master.ar_id     = ar_id_q;
    assign axi_master.ar_burst  = ar_burst_q;
    assign axi_master.ar_size   = AXI_SIZE_64B;
    assign axi_master.ar_prot   = '0;
    assign axi_master.ar_region = '0;
    assign axi_master.ar_lock   = 1'b0;
    assign axi_master.ar_cache  = '0;
    assign axi_master.ar_qos    = '0;
    assign axi_master.ar_user   = '0;

    assign axi_master.r_ready = rx_data_gnt_i;
    assign rx_data_req_o      = axi_master.r_valid;
    assign rx_data_dat_o      = axi_master.r_data;
    assign rx_data_last_o     = axi_master.r_last;
    assign rx_data_tid_o      = EXT_TID_WIDTH'(axi_master.r_id);

    assign release_tid_o = r_last_hs;
    assign synch_req_o   = r_last_hs;
    assign res_tid_o     = EXT_TID_WIDTH'(axi_master.r_id);

    assign unused_inputs = ^{axi_master.r_user, axi_master.r_resp[0],
                             cmd_len_i[MCHAN_LEN_WIDTH-1:11]};

endmodule

// File: tb/tb_ext_rx_if.sv
// Randomized bench for ext_rx_if: a transaction-level model predicts every
// output each cycle, with directed sequences pinning key literal values.
module tb_ext_rx_if;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [28:0] cmd_add;
    logic [14:0] cmd_len;
    logic [3:0]  cmd_tid;
    logic        cmd_bst, cmd_req, cmd_gnt, valid_tid;
    logic        release_tid, synch_req;
    logic [3:0]  res_tid, rx_tid;
    logic [63:0] rx_dat;
    logic        rx_last, rx_req, rx_gnt, err_clr, err;

    int n_checks = 0;
    int n_pass   = 0;

    ext_rx_if_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64),
                   .AXI_USER_WIDTH(6), .AXI_ID_WIDTH(4)) axi ();

    ext_rx_if #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_USER_WIDTH(6),
        .AXI_ID_WIDTH(4), .EXT_ADD_WIDTH(29), .EXT_TID_WIDTH(4),
        .MCHAN_LEN_WIDTH(15), .MAX_OUTSTANDING(8)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_add_i(cmd_add), .cmd_len_i(cmd_len), .cmd_tid_i(cmd_tid),
        .cmd_bst_i(cmd_bst), .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt),
        .valid_tid_i(valid_tid), .release_tid_o(release_tid),
        .res_tid_o(res_tid), .synch_req_o(synch_req),
        .rx_data_dat_o(rx_dat), .rx_data_last_o(rx_last),
        .rx_data_tid_o(rx_tid), .rx_data_req_o(rx_req),
        .rx_data_gnt_i(rx_gnt), .err_clr_i(err_clr), .err_o(err),
        .axi_master(axi)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          m_outst;
    bit          m_pend;
    logic [31:0] m_addr;
    int          m_len;
    logic [3:0]  m_id;
    logic [1:0]  m_burst;
    bit          m_err;

    // Number of 8-byte words touched by [add, add+len], minus one, mod 256.
    function automatic int exp_beats(int add, int len);
        return (((add % 8) + len) / 8) % 256;
    endfunction

    function automatic bit model_gnt();
        return cmd_req && valid_tid && (m_outst < 8) && (!m_pend || axi.ar_ready);
    endfunction

    function automatic bit r_hs();
        return axi.r_valid && rx_gnt;
    endfunction

    function automatic bit r_done();
        return r_hs() && axi.r_last;
    endfunction

    function automatic int next_outst();
        int n;
        n = m_outst + (model_gnt() ? 1 : 0) - (r_done() ? 1 : 0);
        return (n < 0) ? 0 : n;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_outst <= 0;
            m_pend  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            if (model_gnt()) begin
                m_pend  <= 1'b1;
                m_addr  <= {3'b000, cmd_add};
                m_len   <= exp_beats(int'(cmd_add), int'(cmd_len));
                m_id    <= cmd_tid;
                m_burst <= cmd_bst ? 2'b01 : 2'b00;
            end else if (axi.ar_ready) begin
                m_pend <= 1'b0;
            end
            m_outst <= next_outst();
            if (r_hs() && axi.r_resp[1]) m_err <= 1'b1;
            else if (err_clr)            m_err <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst_ni) begin
            chk("rst_ar_valid", 64'(axi.ar_valid), 64'(0));
            chk("rst_err", 64'(err), 64'(0));
        end else begin
            chk("cmd_gnt", 64'(cmd_gnt), 64'(model_gnt()));
            chk("ar_valid", 64'(axi.ar_valid), 64'(m_pend));
            if (m_pend) begin
                chk("ar_addr", 64'(axi.ar_addr), 64'(m_addr));
                chk("ar_len", 64'(axi.ar_len), 64'(m_len));
                chk("ar_id", 64'(axi.ar_id), 64'(m_id));
                chk("ar_burst", 64'(axi.ar_burst), 64'(m_burst));
            end
            chk("ar_size", 64'(axi.ar_size), 64'(3));
            chk("ar_const", 64'({axi.ar_prot, axi.ar_region, axi.ar_lock,
                                 axi.ar_cache, axi.ar_qos, axi.ar_user}), 64'(0));
            chk("r_ready", 64'(axi.r_ready), 64'(rx_gnt));
            chk("rx_req", 64'(rx_req), 64'(axi.r_valid));
            chk("rx_dat", rx_dat, axi.r_data);
            chk("rx_last", 64'(rx_last), 64'(axi.r_last));
            chk("rx_tid", 64'(rx_tid), 64'(axi.r_id));
            chk("release", 64'(release_tid), 64'(r_done()));
            chk("synch", 64'(synch_req), 64'(r_done()));
            if (r_done()) chk("res_tid", 64'(res_tid), 64'(axi.r_id));
            chk("err", 64'(err), 64'(m_err));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_req = 0; cmd_add = '0; cmd_len = '0; cmd_tid = '0; cmd_bst = 0;
        valid_tid = 1; rx_gnt = 1; err_clr = 0;
        axi.ar_ready = 1; axi.r_valid = 0; axi.r_last = 0; axi.r_resp = 2'b00;
        axi.r_id = '0; axi.r_user = '0; axi.r_data = '0;
    endtask

    task automatic send_cmd(input logic [28:0] a, input logic [14:0] l,
                            input logic [3:0] t, input logic b);
        cmd_req = 1; cmd_add = a; cmd_len = l; cmd_tid = t; cmd_bst = b;
    endtask

    task automatic r_beat(input logic last, input logic [3:0] id, input logic [1:0] resp);
        axi.r_valid = 1; axi.r_last = last; axi.r_id = id; axi.r_resp = resp;
        axi.r_data = {$urandom, $urandom};
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            r_beat(1'b1, 4'(i), 2'b00);
            tick();
        end
        axi.r_valid = 0; axi.r_last = 0;
    endtask

    int p_last;

    initial begin
        rst_ni = 0;
        idle();
        tick(); tick();
        rst_ni = 1;
        #1;
        chk("lit_reset_ar_valid", 64'(axi.ar_valid), 64'(0));
        chk("lit_reset_err", 64'(err), 64'(0));

        // single aligned burst, one beat
        send_cmd(29'h0, 15'd7, 4'd5, 1'b1);
        #1 chk("lit_first_gnt", 64'(cmd_gnt), 64'(1));
        tick(); cmd_req = 0;
        #1;
        chk("lit_first_ar_len", 64'(axi.ar_len), 64'(0));
        chk("lit_first_ar_burst", 64'(axi.ar_burst), 64'(2'b01));
        chk("lit_first_ar_id", 64'(axi.ar_id), 64'(5));
        tick();
        r_beat(1'b1, 4'd5, 2'b00);
        #1;
        chk("lit_release", 64'(release_tid), 64'(1));
        chk("lit_res_tid", 64'(res_tid), 64'(5));
        tick(); axi.r_valid = 0; axi.r_last = 0;

        // unaligned start and maximum-length truncation, back to back
        send_cmd(29'h5, 15'd7, 4'd1, 1'b1);
        tick();
        send_cmd(29'h0, 15'd2047, 4'd2, 1'b0);
        #1;
        chk("lit_unaligned_len", 64'(axi.ar_len), 64'(1));
        chk("lit_b2b_gnt", 64'(cmd_gnt), 64'(1));
        tick(); cmd_req = 0;
        #1;
        chk("lit_max_len", 64'(axi.ar_len), 64'(255));
        chk("lit_fixed_burst", 64'(axi.ar_burst), 64'(2'b00));
        tick();
        drain(2);

        // AR backpressure: fields hold, second command waits for ready
        axi.ar_ready = 0;
        send_cmd(29'h100, 15'd31, 4'd3, 1'b1);
        tick();
        send_cmd(29'h208, 15'd15, 4'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("lit_stall_gnt", 64'(cmd_gnt), 64'(0));
            chk("lit_stall_addr", 64'(axi.ar_addr), 64'(32'h100));
            chk("lit_stall_len", 64'(axi.ar_len), 64'(3));
            tick();
        end
        axi.ar_ready = 1;
        #1 chk("lit_ready_gnt", 64'(cmd_gnt), 64'(1));
        tick(); cmd_req = 0;
        #1;
        chk("lit_b2b_valid", 64'(axi.ar_valid), 64'(1));
        chk("lit_b2b_addr", 64'(axi.ar_addr), 64'(32'h208));
        chk("lit_b2b_len", 64'(axi.ar_len), 64'(1));
        tick();
        #1 chk("lit_ar_idle", 64'(axi.ar_valid), 64'(0));
        drain(2);

        // outstanding limit
        for (int i = 0; i < 8; i++) begin
            send_cmd(29'(i * 64), 15'd63, 4'(i), 1'b1);
            #1 chk("lit_fill_gnt", 64'(cmd_gnt), 64'(1));
            tick();
        end
        send_cmd(29'h1000, 15'd7, 4'd9, 1'b1);
        #1 chk("lit_full_gnt", 64'(cmd_gnt), 64'(0));
        r_beat(1'b1, 4'd0, 2'b00);
        #1 chk("lit_full_same_cycle", 64'(cmd_gnt), 64'(0));
        tick(); axi.r_valid = 0; axi.r_last = 0;
        #1 chk("lit_ninth_gnt", 64'(cmd_gnt), 64'(1));
        tick(); cmd_req = 0;

        // R backpressure and error flag
        r_beat(1'b1, 4'd3, 2'b00); rx_gnt = 0;
        #1;
        chk("lit_r_ready_low", 64'(axi.r_ready), 64'(0));
        chk("lit_no_release", 64'(release_tid), 64'(0));
        tick();
        rx_gnt = 1; r_beat(1'b0, 4'd3, 2'b10);
        tick(); axi.r_valid = 0; axi.r_resp = 2'b00;
        #1 chk("lit_err_set", 64'(err), 64'(1));
        tick();
        #1 chk("lit_err_sticky", 64'(err), 64'(1));
        err_clr = 1;
        tick(); err_clr = 0;
        #1 chk("lit_err_clr", 64'(err), 64'(0));
        r_beat(1'b0, 4'd3, 2'b11); err_clr = 1;
        tick(); axi.r_valid = 0; axi.r_resp = 2'b00; err_clr = 0;
        #1 chk("lit_err_set_wins", 64'(err), 64'(1));

        // asynchronous reset with bursts in flight
        drain(1);
        axi.ar_ready = 0;
        send_cmd(29'h2000, 15'd100, 4'd7, 1'b1);
        tick(); cmd_req = 0;
        #2 rst_ni = 0;
        #1;
        chk("lit_async_ar_valid", 64'(axi.ar_valid), 64'(0));
        chk("lit_async_err", 64'(err), 64'(0));
        tick(); tick();
        idle();
        rst_ni = 1;
        for (int i = 0; i < 8; i++) begin
            send_cmd(29'(i * 8), 15'd15, 4'(i), 1'b0);
            #1 chk("lit_post_rst_gnt", 64'(cmd_gnt), 64'(1));
            tick();
        end
        #1 chk("lit_post_rst_full", 64'(cmd_gnt), 64'(0));
        cmd_req = 0;

        // randomized traffic
        p_last = 70;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) p_last = (c / 500) % 3 == 0 ? 70 : ((c / 500) % 3 == 1 ? 5 : 30);
            cmd_req   = $urandom_range(0, 99) < 60;
            valid_tid = $urandom_range(0, 9) != 0;
            cmd_add   = 29'($urandom);
            cmd_len   = ($urandom_range(0, 3) == 0) ? 15'($urandom) : 15'($urandom_range(0, 200));
            cmd_tid   = 4'($urandom);
            cmd_bst   = 1'($urandom);
            axi.ar_ready = $urandom_range(0, 99) < 70;
            axi.r_valid  = $urandom_range(0, 99) < 60;
            axi.r_last   = $urandom_range(0, 99) < p_last;
            axi.r_id     = 4'($urandom);
            axi.r_data   = {$urandom, $urandom};
            axi.r_resp   = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
            rx_gnt       = $urandom_range(0, 99) < 80;
            err_clr      = $urandom_range(0, 19) == 0;
            if (c == 2000) begin
                #2 rst_ni = 0;
                #1;
                chk("rand_async_ar_valid", 64'(axi.ar_valid), 64'(0));
                tick();
                rst_ni = 1;
            end
            tick();
        end

        idle();
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
